// File: rtl/mipi_dphy_mmcm_drp_sequencer_if.sv
// DRP bus between the reconfiguration sequencer (master) and the MMCM DRP port (slave).
interface mipi_dphy_mmcm_drp_sequencer_if;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output drp_daddr, drp_den, drp_dwe, drp_di,
        input  drp_do, drp_drdy
    );

    modport slave (
        input  drp_daddr, drp_den, drp_dwe, drp_di,
        output drp_do, drp_drdy
    );
endinterface

// File: rtl/mipi_dphy_mmcm_drp_sequencer.sv
// Reconfigures the D-PHY serial-clock MMCM: holds it in reset, read-modify-writes a
// table of DRP registers, releases reset and waits for lock, with DRDY/lock timeouts.
module mipi_dphy_mmcm_drp_sequencer #(
    parameter int NUM_REGS     = 8,
    parameter int RST_HOLD     = 16,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 1048576
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [$clog2(NUM_REGS+1)-1:0]     cfg_count,
    input  logic [NUM_REGS-1:0][6:0]          cfg_addr,
    input  logic [NUM_REGS-1:0][15:0]         cfg_mask,
    input  logic [NUM_REGS-1:0][15:0]         cfg_data,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic                              err_lock,
    mipi_dphy_mmcm_drp_sequencer_if.master    drp,
    output logic                              mmcm_rst,
    input  logic                              mmcm_locked
);
    localparam int CW     = $clog2(NUM_REGS + 1);
    localparam int IW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int T_WAIT = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int T_MAX  = (T_WAIT > RST_HOLD) ? T_WAIT : RST_HOLD;
    localparam int TW     = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_RELEASE, S_LOCK_WAIT, S_DONE
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] idx;
    logic [CW-1:0] count_q;
    logic [15:0]   do_cap;
    logic [TW-1:0] timer;
    logic          locked_meta, locked_sync;
    logic          drdy_expired, lock_expired, idx_advance, last_entry;

    assign last_entry = (CW'(idx) == count_q - CW'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // One shared timer, cleared on every state change, serves the reset hold and both timeouts.
    always_comb begin
        state_next    = state;
        busy          = 1'b0;
        done          = 1'b0;
        mmcm_rst      = 1'b0;
        drp.drp_den   = 1'b0;
        drp.drp_dwe   = 1'b0;
        drp.drp_daddr = '0;
        drp.drp_di    = '0;
        drdy_expired  = 1'b0;
        lock_expired  = 1'b0;
        idx_advance   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_RST;
            end
            S_RST: begin
                busy     = 1'b1;
                mmcm_rst = 1'b1;
                if (timer == TW'(RST_HOLD - 1))
                    state_next = (count_q == '0) ? S_RELEASE : S_RD;
            end
            S_RD: begin
                busy          = 1'b1;
                mmcm_rst      = 1'b1;
                drp.drp_den   = 1'b1;
                drp.drp_daddr = cfg_addr[idx];
                state_next    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                busy          = 1'b1;
                mmcm_rst      = 1'b1;
                drp.drp_daddr = cfg_addr[idx];
                if (drp.drp_drdy) begin
                    state_next = S_WR;
                end else if (timer == TW'(DRDY_TIMEOUT - 1)) begin
                    drdy_expired = 1'b1;
                    state_next   = S_RELEASE;
                end
            end
            S_WR: begin
                busy          = 1'b1;
                mmcm_rst      = 1'b1;
                drp.drp_den   = 1'b1;
                drp.drp_dwe   = 1'b1;
                drp.drp_daddr = cfg_addr[idx];
                drp.drp_di    = (do_cap & cfg_mask[idx]) | (cfg_data[idx] & ~cfg_mask[idx]);
                state_next    = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                busy          = 1'b1;
                mmcm_rst      = 1'b1;
                drp.drp_daddr = cfg_addr[idx];
                if (drp.drp_drdy) begin
                    if (last_entry) begin
                        state_next = S_RELEASE;
                    end else begin
                        idx_advance = 1'b1;
                        state_next  = S_RD;
                    end
                end else if (timer == TW'(DRDY_TIMEOUT - 1)) begin
                    drdy_expired = 1'b1;
                    state_next   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                busy       = 1'b1;
                // A DRP timeout leaves the MMCM half-programmed; waiting for lock is pointless.
                state_next = error ? S_DONE : S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                busy = 1'b1;
                if (locked_sync) begin
                    state_next = S_DONE;
                end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                    lock_expired = 1'b1;
                    state_next   = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            count_q     <= '0;
            do_cap      <= '0;
            timer       <= '0;
            locked_meta <= 1'b0;
            locked_sync <= 1'b0;
            error       <= 1'b0;
            err_lock    <= 1'b0;
        end else begin
            locked_meta <= mmcm_locked;
            locked_sync <= locked_meta;
            timer       <= (state_next != state) ? '0 : timer + TW'(1);
            if (state == S_IDLE && start) begin
                error    <= 1'b0;
                err_lock <= 1'b0;
                idx      <= '0;
                count_q  <= (cfg_count > CW'(NUM_REGS)) ? CW'(NUM_REGS) : cfg_count;
            end
            if (state == S_RD_WAIT && drp.drp_drdy) do_cap <= drp.drp_do;
            if (idx_advance) idx <= idx + IW'(1);
            if (drdy_expired) begin
                error    <= 1'b1;
                err_lock <= 1'b0;
            end
            if (lock_expired) begin
                error    <= 1'b1;
                err_lock <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mipi_dphy_mmcm_drp_sequencer.sv
// Self-checking bench: DRP register-file model with fixed latency, MMCM lock model,
// and a scoreboard of expected DRP transactions checked on every DEN pulse.
module tb_mipi_dphy_mmcm_drp_sequencer;
    localparam int NUM_REGS     = 8;
    localparam int RST_HOLD     = 16;
    localparam int DRDY_TIMEOUT = 64;
    localparam int LOCK_TIMEOUT = 100;
    localparam int LAT          = 3;
    localparam int CW           = $clog2(NUM_REGS + 1);

    typedef struct {
        logic [6:0]  addr;
        logic        we;
        logic [15:0] di;
    } drp_txn_t;

    typedef struct {
        int          count;
        int          n_exp;
        logic [6:0]  base;
        logic [15:0] mask;
        logic [15:0] data;
        logic [15:0] init;
        logic [15:0] exp_di0;
    } vec_t;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      start = 1'b0;
    logic [CW-1:0]             cfg_count = '0;
    logic [NUM_REGS-1:0][6:0]  cfg_addr = '0;
    logic [NUM_REGS-1:0][15:0] cfg_mask = '0;
    logic [NUM_REGS-1:0][15:0] cfg_data = '0;
    logic                      busy, done, error, err_lock, mmcm_rst;
    logic                      mmcm_locked = 1'b0;

    mipi_dphy_mmcm_drp_sequencer_if drp();

    mipi_dphy_mmcm_drp_sequencer #(
        .NUM_REGS(NUM_REGS), .RST_HOLD(RST_HOLD),
        .DRDY_TIMEOUT(DRDY_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_count(cfg_count),
        .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error), .err_lock(err_lock),
        .drp(drp), .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem [128];
    drp_txn_t    exp_q [$];
    drp_txn_t    mon_t;
    int          pend = 0;
    logic [6:0]  pend_addr = '0;
    logic        drop_next_read = 1'b0;
    logic        lock_enable = 1'b1;
    int          lock_cnt = 0;
    int          rst_cycles = 0;
    int          done_count = 0;
    int          write_count = 0;
    vec_t        vecs [6];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // DRP slave, lock model and transaction scoreboard, all evaluated just after each rising edge.
    initial begin
        drp.drp_drdy = 1'b0;
        drp.drp_do   = '0;
        forever begin
            @(posedge clk);
            #1;
            drp.drp_drdy = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drp.drp_drdy = 1'b1;
                    drp.drp_do   = mem[pend_addr];
                end
            end
            if (mmcm_rst) begin
                rst_cycles++;
                lock_cnt = 0;
            end else if (lock_enable && lock_cnt < 5) begin
                lock_cnt++;
            end
            mmcm_locked = lock_enable && (lock_cnt >= 5);
            if (done) done_count++;
            if (drp.drp_den) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_den: addr 0x%0h we %0b, expected no transaction",
                             drp.drp_daddr, drp.drp_dwe);
                end else begin
                    mon_t = exp_q.pop_front();
                    if (drp.drp_daddr !== mon_t.addr || drp.drp_dwe !== mon_t.we ||
                        (mon_t.we && drp.drp_di !== mon_t.di)) begin
                        errors++;
                        $display("[TB] FAIL drp_txn: got addr 0x%0h we %0b di 0x%0h, expected addr 0x%0h we %0b di 0x%0h",
                                 drp.drp_daddr, drp.drp_dwe, drp.drp_di, mon_t.addr, mon_t.we, mon_t.di);
                    end
                end
                if (drp.drp_dwe) begin
                    mem[drp.drp_daddr] = drp.drp_di;
                    write_count++;
                end
                if (drop_next_read && !drp.drp_dwe) begin
                    drop_next_read = 1'b0;
                end else begin
                    pend      = LAT;
                    pend_addr = drp.drp_daddr;
                end
            end
        end
    end

    task automatic apply_stimulus(input vec_t v);
        logic [15:0] cur, wd;
        for (int i = 0; i < NUM_REGS; i++) begin
            cfg_addr[i] = v.base + 7'(3 * i);
            cfg_mask[i] = v.mask ^ 16'(i * 16'h0101);
            cfg_data[i] = v.data + 16'(i * 16'h1234);
            mem[cfg_addr[i]] = v.init ^ 16'(i * 16'h0F0F);
        end
        for (int i = 0; i < v.n_exp; i++) begin
            cur = v.init ^ 16'(i * 16'h0F0F);
            wd  = (cur & cfg_mask[i]) | (cfg_data[i] & ~cfg_mask[i]);
            exp_q.push_back('{cfg_addr[i], 1'b0, 16'h0000});
            exp_q.push_back('{cfg_addr[i], 1'b1, wd});
        end
        cfg_count  = CW'(v.count);
        rst_cycles = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        int start_cnt;
        int n;
        start_cnt = done_count;
        n = 0;
        while (done_count == start_cnt && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output({name, "_done"}, 32'(done_count != start_cnt), 32'd1);
    endtask

    initial begin
        int n;
        int d0;
        vecs[0] = '{1,  1, 7'h08, 16'hF000, 16'h0145, 16'hA7FF, 16'hA145};
        vecs[1] = '{3,  3, 7'h10, 16'h00FF, 16'hABCD, 16'h1234, 16'hAB34};
        vecs[2] = '{0,  0, 7'h30, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{15, 8, 7'h20, 16'h0F0F, 16'h5A5A, 16'hC3C3, 16'h5353};
        vecs[4] = '{8,  8, 7'h40, 16'hFFFF, 16'h0000, 16'h7777, 16'h7777};
        vecs[5] = '{2,  2, 7'h01, 16'h0000, 16'hBEEF, 16'h1111, 16'hBEEF};

        repeat (3) @(negedge clk);
        check_output("reset_ctrl", {busy, done, error, err_lock, mmcm_rst, drp.drp_den, drp.drp_dwe}, 0);
        check_output("reset_bus", {drp.drp_daddr, drp.drp_di}, 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            apply_stimulus(vecs[v]);
            check_output($sformatf("vec%0d_busy", v), busy, 1);
            wait_done(1000, $sformatf("vec%0d", v));
            check_output($sformatf("vec%0d_flags", v), {busy, error, err_lock, mmcm_rst}, 0);
            check_output($sformatf("vec%0d_queue", v), exp_q.size(), 0);
            check_output($sformatf("vec%0d_rst_cycles", v), rst_cycles, RST_HOLD + vecs[v].n_exp * (2 * LAT + 2));
            if (vecs[v].n_exp > 0)
                check_output($sformatf("vec%0d_reg0", v), mem[vecs[v].base], vecs[v].exp_di0);
            repeat (3) @(negedge clk);
        end

        // DRDY never returned on the first read.
        drop_next_read = 1'b1;
        exp_q.push_back('{7'h60, 1'b0, 16'h0000});
        d0 = write_count;
        apply_stimulus('{2, 0, 7'h60, 16'h00FF, 16'h1234, 16'h5555, 16'h0000});
        wait_done(1000, "drdy_to");
        check_output("drdy_to_flags", {error, err_lock, mmcm_rst}, 3'b100);
        check_output("drdy_to_no_write", write_count, d0);
        check_output("drdy_to_queue", exp_q.size(), 0);
        check_output("drdy_to_rst_window",
                     32'(rst_cycles >= RST_HOLD + DRDY_TIMEOUT && rst_cycles <= RST_HOLD + DRDY_TIMEOUT + 2), 1);
        repeat (3) @(negedge clk);

        // Lock never asserted, then a fresh start clears the sticky error.
        lock_enable = 1'b0;
        apply_stimulus(vecs[0]);
        wait_done(1000, "lock_to");
        check_output("lock_to_flags", {error, err_lock}, 2'b11);
        check_output("lock_to_queue", exp_q.size(), 0);
        lock_enable = 1'b1;
        repeat (10) @(negedge clk);
        check_output("lock_to_sticky", {error, err_lock}, 2'b11);
        apply_stimulus(vecs[2]);
        check_output("restart_clears", {busy, mmcm_rst, error, err_lock}, 4'b1100);
        wait_done(1000, "restart");
        check_output("restart_flags", {error, err_lock}, 0);
        repeat (3) @(negedge clk);

        // Reset during WR_WAIT, then a clean run with a stray start while busy.
        d0 = write_count;
        apply_stimulus('{3, 3, 7'h70, 16'hF0F0, 16'h1357, 16'h2468, 16'h0000});
        n = 0;
        while (write_count == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("mid_reset_reached_wr", 32'(write_count != d0), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("mid_reset_ctrl", {busy, done, error, err_lock, mmcm_rst, drp.drp_den, drp.drp_dwe}, 0);
        check_output("mid_reset_bus", {drp.drp_daddr, drp.drp_di}, 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (6) @(negedge clk);
        d0 = done_count;
        apply_stimulus(vecs[1]);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1000, "after_reset");
        repeat (40) @(negedge clk);
        check_output("after_reset_one_done", done_count, d0 + 1);
        check_output("after_reset_idle", {busy, error, err_lock}, 0);
        check_output("after_reset_queue", exp_q.size(), 0);
        check_output("after_reset_reg0", mem[vecs[1].base], vecs[1].exp_di0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
